key_press_repeat: RTL and testbench
===================================

Name: key_press_repeat

Overview:
- Upstream key-conditioning stage for the LED counter.
- Takes one raw, asynchronous push-key input and synchronizes it to clk.
- Debounces it, then emits single-cycle press, release and auto-repeat event pulses.
- press_pulse|repeat_pulse is the count enable for the downstream LED counter. That counter clocks on clk instead of on a derived key clock.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronized samples that must disagree with the stable level before it flips (20 ms at 50 MHz); >=2.
- LONG_CYCLES, 50000000, cycles a debounced press must persist before auto-repeat starts; >=2.
- REPEAT_CYCLES, 10000000, period of repeat_pulse once auto-repeat is active; >=2.
- KEY_ACTIVE_LOW, 1, 1: raw key=0 means pressed; 0: raw key=1 means pressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  1  raw asynchronous push-key pin.
- key_level  output  1  debounced pressed level (1 = pressed).
- press_pulse  output  1  one-cycle pulse on each accepted press.
- release_pulse  output  1  one-cycle pulse on each accepted release.
- repeat_pulse  output  1  one-cycle pulse per auto-repeat tick.
- long_hold  output  1  high while auto-repeat is active.

Behaviour:
- Reset (rst=1 at an edge) takes effect at that edge, overriding all other activity:
  - Synchronizer flops load the released value.
  - Stable level = released; debounce and hold counters = 0; state = IDLE.
  - All outputs = 0.
- Synchronizer: two flops, then polarity normalization to pressed=1. key_sync lags key by 2 cycles.
- Debounce:
  - A counter increments every cycle key_sync != stable level.
  - It clears to 0 in any cycle key_sync == stable level.
  - Let t0 be the first disagreeing cycle. If disagreement persists through t0+DEBOUNCE_CYCLES-1, the stable level flips at the end of that cycle and is visible from t0+DEBOUNCE_CYCLES. The counter clears at the same time.
- key_level is the stable level, registered.
- States: IDLE, PRESSED, REPEAT.
  - IDLE -> PRESSED on a stable 0->1 flip. press_pulse=1 in the same cycle key_level first reads 1. Hold counter cleared.
  - In PRESSED, the hold counter increments each cycle. When it reaches LONG_CYCLES-1 it clears and the state moves to REPEAT. In that first REPEAT cycle long_hold=1 and repeat_pulse=1 together. First repeat tick is LONG_CYCLES cycles after press_pulse.
  - In REPEAT, the hold counter increments each cycle. repeat_pulse=1 for one cycle every REPEAT_CYCLES cycles, and the counter wraps to 0 on each pulse.
  - PRESSED or REPEAT -> IDLE on a stable 1->0 flip. release_pulse=1 in the same cycle key_level first reads 0. long_hold=0 and repeat_pulse=0 that cycle. Hold counter cleared.
- Only one flip is possible per cycle, so press and release never coincide.
- A release flip in the same cycle a repeat tick would fire suppresses the tick; release wins.
- Counter widths are $clog2(param+1). Counters never overflow: they saturate and clear at their terminal values.
- Reset mid-hold gives no release_pulse. If the key is still pressed after rst drops, a fresh debounce yields a new press_pulse after 2+DEBOUNCE_CYCLES cycles.
- All outputs are registered. There are no combinational paths from key to any output.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, KEY_ACTIVE_LOW=1. rst held 3 cycles, then released with key=1.
- Bounce: toggle key every 2 cycles for 30 cycles, then return to key=1 -> key_level stays 0; no pulses of any kind.
- Clean short press: key=0 at cycle T, held 12 cycles, then key=1:
  - press_pulse exactly once at T+6 (2 sync + 4 debounce), key_level=1 from T+6.
  - release_pulse exactly once at T+18.
  - No repeat_pulse; long_hold never set.
- Long hold: key=0 held 70 cycles after acceptance at cycle P:
  - long_hold=1 from P+20.
  - repeat_pulse at P+20, P+28, P+36, P+44, P+52, P+60, P+68.
  - On release: release_pulse once; long_hold=0 in that same cycle.
- Reset mid-REPEAT: assert rst 1 cycle at P+30 with key held:
  - All outputs 0 from P+31; no release_pulse.
  - After rst drops, press_pulse again 6 cycles later, followed by a new 20-cycle long-press interval.
- Polarity: KEY_ACTIVE_LOW=0, key=1 held 10 cycles -> press_pulse at +6; key=0 -> release_pulse at +6.

Source files
------------

// File: rtl/key_press_repeat.sv
// Push-key conditioner: 2-flop synchronizer, debounce, and press/release/auto-repeat pulses
// whose press|repeat OR serves as a clk-domain count enable downstream.
module key_press_repeat #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_hold
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic RELEASED_RAW = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  logic              sync1_q, sync2_q;
  logic              key_sync;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              stable_q, stable_d;
  logic              disagree, flip, rise, fall;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              press_q, release_q, repeat_q, long_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RELEASED_RAW;
      sync2_q <= RELEASED_RAW;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign disagree = (key_sync != stable_q);
  // The flip lands on the D-th consecutive disagreeing cycle; counter clears with it.
  assign flip     = disagree && (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise     = flip && key_sync;
  assign fall     = flip && !key_sync;

  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (!disagree || flip) db_cnt_d = '0;
    else                   db_cnt_d = db_cnt_q + 1'b1;
    if (flip) stable_d = key_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= PRESSED;
            hold_q  <= '0;
            press_q <= 1'b1;
            long_q  <= 1'b0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            release_q <= 1'b1;
          end else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
            state_q  <= REPEAT;
            hold_q   <= '0;
            long_q   <= 1'b1;
            repeat_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        REPEAT: begin
          // A release on a tick cycle takes priority and swallows the tick.
          if (fall) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            release_q <= 1'b1;
            long_q    <= 1'b0;
          end else if (hold_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
            hold_q   <= '0;
            repeat_q <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
          long_q  <= 1'b0;
        end
      endcase
    end
  end

  assign key_level     = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign long_hold     = long_q;

endmodule

// File: tb/tb_key_press_repeat.sv
// Bench for key_press_repeat: active-low and active-high instances checked cycle by cycle
// against an event/age-based reference model, plus directed timing scenarios.
module tb_key_press_repeat;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b1;
  logic key2 = 1'b0;

  logic lvl_a, prs_a, rel_a, rpt_a, lng_a;
  logic lvl_b, prs_b, rel_b, rpt_b, lng_b;
  logic [4:0] va, vb;

  assign va = {lvl_a, prs_a, rel_a, rpt_a, lng_a};
  assign vb = {lvl_b, prs_b, rel_b, rpt_b, lng_b};

  always #5 clk = ~clk;

  key_press_repeat #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .KEY_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst(rst), .key(key), .key_level(lvl_a), .press_pulse(prs_a),
    .release_pulse(rel_a), .repeat_pulse(rpt_a), .long_hold(lng_a));

  key_press_repeat #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .KEY_ACTIVE_LOW(0)) u_pol (
    .clk(clk), .rst(rst), .key(key2), .key_level(lvl_b), .press_pulse(prs_b),
    .release_pulse(rel_b), .repeat_pulse(rpt_b), .long_hold(lng_b));

  // Reference: stable level flips after D straight disagreeing samples; age counts
  // cycles since the press became visible; ticks fall at age L, L+R, L+2R, ...
  typedef struct packed {
    logic       s0;
    logic       s1;
    logic       stable;
    int         run;
    int         age;
    logic [4:0] outv;
  } mstate_t;

  mstate_t ma = '0;
  mstate_t mb = '0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  function automatic mstate_t step(mstate_t m, logic k, logic r, logic al);
    mstate_t n;
    logic ks, rise, fall, lh, rp;
    n = m;
    if (r) begin
      n.s0 = al; n.s1 = al; n.stable = 1'b0; n.run = 0; n.age = 0; n.outv = '0;
      return n;
    end
    ks = al ? ~m.s1 : m.s1;
    n.s1 = m.s0;
    n.s0 = k;
    rise = 1'b0;
    fall = 1'b0;
    if (ks != m.stable) begin
      n.run = m.run + 1;
      if (n.run == D) begin
        n.stable = ks; n.run = 0; rise = ks; fall = ~ks;
      end
    end else begin
      n.run = 0;
    end
    if (rise) n.age = 0;
    else if (n.stable) n.age = m.age + 1;
    lh = n.stable && (n.age >= L);
    rp = lh && (((n.age - L) % R) == 0);
    n.outv = {n.stable, rise, fall, rp, lh};
    return n;
  endfunction

  always @(posedge clk) begin
    ma  <= step(ma, key, rst, 1'b1);
    mb  <= step(mb, key2, rst, 1'b0);
    cyc <= cyc + 1;
  end

  task automatic test_reset();
    rst = 1'b1; key = 1'b1; key2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (va !== 5'b0 || vb !== 5'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got a=%b b=%b required 00000", cyc, va, vb);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    int npulse = 0;
    int nlvl = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL bounce_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (prs_a || rel_a || rpt_a || lng_a) npulse++;
      if (lvl_a) nlvl++;
      key = (i < 30) ? (((i / 2) % 2) != 0) : 1'b1;
    end
    tests++;
    if (npulse !== 0 || nlvl !== 0) begin
      fails++;
      $display("FAIL bounce_quiet got pulses=%0d level_cycles=%0d required 0 0", npulse, nlvl);
    end
  endtask

  task automatic test_short_press();
    int np = 0, nr = 0, nrp = 0, nl = 0, pat = -1, rat = -1;
    logic lvl5 = 1'b0, lvl6 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL short_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (prs_a) begin np++; pat = i; end
      if (rel_a) begin nr++; rat = i; end
      if (rpt_a) nrp++;
      if (lng_a) nl++;
      if (i == 5) lvl5 = lvl_a;
      if (i == 6) lvl6 = lvl_a;
      key = (i < 12) ? 1'b0 : 1'b1;
    end
    tests++;
    if (np !== 1 || pat !== 6) begin
      fails++; $display("FAIL short_press got count=%0d at=%0d required 1 at 6", np, pat);
    end
    tests++;
    if (nr !== 1 || rat !== 18) begin
      fails++; $display("FAIL short_release got count=%0d at=%0d required 1 at 18", nr, rat);
    end
    tests++;
    if (nrp !== 0 || nl !== 0) begin
      fails++; $display("FAIL short_norepeat got repeat=%0d long=%0d required 0 0", nrp, nl);
    end
    tests++;
    if (lvl5 !== 1'b0 || lvl6 !== 1'b1) begin
      fails++; $display("FAIL short_level got lvl5=%b lvl6=%b required 0 1", lvl5, lvl6);
    end
  endtask

  task automatic test_long_hold();
    int rq[$];
    int nr = 0, rat = -1, lfirst = -1;
    logic l81 = 1'b0, l82 = 1'b1;
    for (int i = 0; i < 95; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL long_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (rpt_a) rq.push_back(i);
      if (rel_a) begin nr++; rat = i; end
      if (lng_a && lfirst < 0) lfirst = i;
      if (i == 81) l81 = lng_a;
      if (i == 82) l82 = lng_a;
      key = (i < 76) ? 1'b0 : 1'b1;
    end
    tests++;
    if (rq.size() !== 7) begin
      fails++; $display("FAIL long_repeat_count got %0d required 7", rq.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        tests++;
        if (rq[k] !== 6 + L + k * R) begin
          fails++; $display("FAIL long_repeat_at[%0d] got %0d required %0d", k, rq[k], 6 + L + k * R);
        end
      end
    end
    tests++;
    if (lfirst !== 6 + L) begin
      fails++; $display("FAIL long_hold_start got %0d required %0d", lfirst, 6 + L);
    end
    tests++;
    if (nr !== 1 || rat !== 82 || l81 !== 1'b1 || l82 !== 1'b0) begin
      fails++;
      $display("FAIL long_release got count=%0d at=%0d long81=%b long82=%b required 1 82 1 0", nr, rat, l81, l82);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int pq[$];
    int rq[$];
    int nr_early = 0, rat = -1;
    logic [4:0] v37 = 5'h1f;
    for (int i = 0; i < 86; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL rstmid_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (prs_a) pq.push_back(i);
      if (rpt_a) rq.push_back(i);
      if (rel_a) begin
        if (i < 70) nr_early++;
        rat = i;
      end
      if (i == 37) v37 = va;
      rst = (i == 36);
      key = (i < 70) ? 1'b0 : 1'b1;
    end
    rst = 1'b0;
    tests++;
    if (v37 !== 5'b0 || nr_early !== 0) begin
      fails++; $display("FAIL rstmid_clear got outputs=%b early_release=%0d required 00000 0", v37, nr_early);
    end
    tests++;
    if (pq.size() !== 2 || pq[0] !== 6 || pq[1] !== 43) begin
      fails++; $display("FAIL rstmid_press got n=%0d first=%0d second=%0d required 2 6 43",
                        pq.size(), (pq.size() > 0) ? pq[0] : -1, (pq.size() > 1) ? pq[1] : -1);
    end
    tests++;
    if (rq.size() !== 4 || rq[0] !== 26 || rq[1] !== 34 || rq[2] !== 63 || rq[3] !== 71) begin
      fails++; $display("FAIL rstmid_repeat got n=%0d third=%0d required 4 with third 63",
                        rq.size(), (rq.size() > 2) ? rq[2] : -1);
    end
    tests++;
    if (rat !== 76) begin
      fails++; $display("FAIL rstmid_release got at=%0d required 76", rat);
    end
  endtask

  task automatic test_polarity();
    int np = 0, nr = 0, pat = -1, rat = -1;
    logic l10 = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL pol_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (prs_b) begin np++; pat = i; end
      if (rel_b) begin nr++; rat = i; end
      if (i == 10) l10 = lvl_b;
      key2 = (i < 10) ? 1'b1 : 1'b0;
    end
    tests++;
    if (np !== 1 || pat !== 6 || nr !== 1 || rat !== 16 || l10 !== 1'b1) begin
      fails++;
      $display("FAIL polarity got press=%0d@%0d release=%0d@%0d lvl10=%b required 1@6 1@16 1", np, pat, nr, rat, l10);
    end
  endtask

  task automatic test_random();
    int hold_a = 0, hold_b = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      tests++;
      if ({va, vb} !== {ma.outv, mb.outv}) begin
        fails++;
        $display("FAIL random_model cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, va, vb, ma.outv, mb.outv);
      end
      if (hold_a == 0) begin key = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 40); end
      else hold_a--;
      if (hold_b == 0) begin key2 = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 40); end
      else hold_b--;
      rst = ($urandom_range(0, 249) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_long_hold();
    test_reset_mid_repeat();
    test_polarity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
